// File: rtl/fetch_control_unit.sv
// Fetch-stage sequencing controller: arbitrates PC redirects against load-use stalls and imem wait.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_control_unit #(
   parameter int RESET_HOLD_CYCLES = 2,
   parameter int LOAD_STALL_CYCLES = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        BranchTaken,
   input  logic        JumpReq,
   input  logic        JrReq,
   input  logic        LoadUseHazard,
   input  logic        IMemReady,
   output logic        PCSrc,
   output logic [1:0]  sel,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        IFIDFlush,
   output logic        IDEXBubble,
   output logic [1:0]  CtrlState
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] RedirectCount,
   output logic [31:0] StallCount,
   output logic [31:0] IMemWaitCount
`endif
);

   typedef enum logic [1:0] {
      ST_HOLD  = 2'b00,
      ST_RUN   = 2'b01,
      ST_STALL = 2'b10
   } state_t;

   localparam logic [3:0] HOLD_INIT  = 4'(RESET_HOLD_CYCLES - 1);
   localparam logic [3:0] STALL_INIT = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;

   state_t     state_q, state_d;
   logic [3:0] count_q, count_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_HOLD;
         count_q <= HOLD_INIT;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Defaults are the hold/reset outputs; each state only overrides what differs.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      PCSrc      = 1'b0;
      sel        = 2'b00;
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
      CtrlState  = state_q;
      if (!Reset) begin
         case (state_q)
            ST_HOLD: begin
               if (count_q == 4'd0) begin
                  state_d = ST_RUN;
               end else begin
                  count_d = count_q - 4'd1;
               end
            end
            ST_STALL: begin
               IFIDFlush = 1'b0;
               if (count_q == 4'd0) begin
                  state_d = ST_RUN;
               end else begin
                  count_d = count_q - 4'd1;
               end
            end
            ST_RUN: begin
               if (LoadUseHazard) begin
                  IFIDFlush = 1'b0;
                  if (LOAD_STALL_CYCLES > 1) begin
                     state_d = ST_STALL;
                     count_d = STALL_INIT;
                  end
               end else if (JrReq || JumpReq || BranchTaken) begin
                  PCWrite    = 1'b1;
                  IFIDWrite  = 1'b1;
                  IDEXBubble = 1'b0;
                  if (JrReq) begin
                     sel = 2'b10;
                  end else if (JumpReq) begin
                     sel = 2'b01;
                  end else begin
                     PCSrc = 1'b1;
                  end
               end else if (!IMemReady) begin
                  // Load a NOP so the instruction already in ID is not executed twice.
                  IFIDWrite  = 1'b1;
                  IDEXBubble = 1'b0;
               end else begin
                  PCWrite    = 1'b1;
                  IFIDWrite  = 1'b1;
                  IFIDFlush  = 1'b0;
                  IDEXBubble = 1'b0;
               end
            end
            default: begin
               state_d = ST_HOLD;
               count_d = HOLD_INIT;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] redirect_cnt_q, redirect_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] wait_cnt_q, wait_cnt_d;

   // A redirect is the only case with PCWrite and IFIDFlush together; an imem wait the only
   // case writing IF/ID without advancing the PC.
   always_comb begin
      redirect_cnt_d = redirect_cnt_q + {31'd0, PCWrite & IFIDFlush};
      stall_cnt_d    = stall_cnt_q + {31'd0, IDEXBubble & (state_q != ST_HOLD)};
      wait_cnt_d     = wait_cnt_q + {31'd0, ~PCWrite & IFIDWrite};
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         redirect_cnt_q <= 32'd0;
         stall_cnt_q    <= 32'd0;
         wait_cnt_q     <= 32'd0;
      end else begin
         redirect_cnt_q <= redirect_cnt_d;
         stall_cnt_q    <= stall_cnt_d;
         wait_cnt_q     <= wait_cnt_d;
      end
   end

   assign RedirectCount = redirect_cnt_q;
   assign StallCount    = stall_cnt_q;
   assign IMemWaitCount = wait_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_control_unit.sv
// Self-checking bench for fetch_control_unit: fixed vector table, hand sequences and a random run.
module tb_fetch_control_unit;

   localparam int H = 2;
   localparam int L = 3;

   // Output groups {PCSrc, sel, PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}
   localparam logic [6:0] O_RST  = 7'b0000011;
   localparam logic [6:0] O_RUN  = 7'b0001100;
   localparam logic [6:0] O_BUB  = 7'b0000001;
   localparam logic [6:0] O_WAIT = 7'b0000110;
   localparam logic [6:0] O_JR   = 7'b0101110;
   localparam logic [6:0] O_J    = 7'b0011110;
   localparam logic [6:0] O_BR   = 7'b1001110;

   logic Clk = 1'b0;
   logic Reset, BranchTaken, JumpReq, JrReq, LoadUseHazard, IMemReady;
   logic PCSrc, PCWrite, IFIDWrite, IFIDFlush, IDEXBubble;
   logic [1:0] sel, CtrlState;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] RedirectCount, StallCount, IMemWaitCount;
`endif

   fetch_control_unit #(
      .RESET_HOLD_CYCLES(H),
      .LOAD_STALL_CYCLES(L)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .BranchTaken(BranchTaken),
      .JumpReq(JumpReq),
      .JrReq(JrReq),
      .LoadUseHazard(LoadUseHazard),
      .IMemReady(IMemReady),
      .PCSrc(PCSrc),
      .sel(sel),
      .PCWrite(PCWrite),
      .IFIDWrite(IFIDWrite),
      .IFIDFlush(IFIDFlush),
      .IDEXBubble(IDEXBubble),
      .CtrlState(CtrlState)
`ifdef FETCH_PERF_CNT_EN
      ,
      .RedirectCount(RedirectCount),
      .StallCount(StallCount),
      .IMemWaitCount(IMemWaitCount)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       rst, br, jmp, jr, lu, rdy;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[$];
   int n_checks = 0;
   int n_fail = 0;
   int hold_left = 0;
   int stall_left = 0;
   int m_redir = 0;
   int m_stall = 0;
   int m_wait = 0;
   logic [8:0] last_out;

   task automatic addVec(input logic rst, br, jmp, jr, lu, rdy, input logic [6:0] o, input logic [1:0] st);
      vec_t v;
      v.rst = rst; v.br = br; v.jmp = jmp; v.jr = jr; v.lu = lu; v.rdy = rdy;
      v.exp = {o, st};
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, predict from cycle-count rules, compare at the falling edge.
   task automatic applyStimulus(input logic rst, br, jmp, jr, lu, rdy, input string tag);
      logic [6:0] o;
      logic [1:0] st;
      Reset = rst; BranchTaken = br; JumpReq = jmp; JrReq = jr;
      LoadUseHazard = lu; IMemReady = rdy;
      @(negedge Clk);
      st = (hold_left > 0) ? 2'b00 : ((stall_left > 0) ? 2'b10 : 2'b01);
      if (rst) begin
         o = O_RST; hold_left = H; stall_left = 0;
         m_redir = 0; m_stall = 0; m_wait = 0;
      end else if (hold_left > 0) begin
         o = O_RST; hold_left--;
      end else if (stall_left > 0) begin
         o = O_BUB; stall_left--; m_stall++;
      end else if (lu) begin
         o = O_BUB; stall_left = L - 1; m_stall++;
      end else if (jr) begin
         o = O_JR; m_redir++;
      end else if (jmp) begin
         o = O_J; m_redir++;
      end else if (br) begin
         o = O_BR; m_redir++;
      end else if (!rdy) begin
         o = O_WAIT; m_wait++;
      end else begin
         o = O_RUN;
      end
      last_out = {PCSrc, sel, PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, CtrlState};
      checkOutput(tag, 32'(last_out), 32'({o, st}));
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int found;
      Reset = 1'b1; BranchTaken = 1'b0; JumpReq = 1'b0; JrReq = 1'b0;
      LoadUseHazard = 1'b0; IMemReady = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      hold_left = H;
      stall_left = 0;

      // rst br jmp jr lu rdy
      addVec(1, 0, 0, 0, 0, 1, O_RST, 2'b00);
      addVec(1, 0, 0, 0, 0, 1, O_RST, 2'b00);
      addVec(1, 0, 0, 0, 0, 1, O_RST, 2'b00);
      addVec(0, 0, 0, 1, 0, 1, O_RST, 2'b00);
      addVec(0, 0, 0, 0, 1, 1, O_RST, 2'b00);
      addVec(0, 0, 0, 0, 0, 1, O_RUN, 2'b01);
      addVec(0, 1, 1, 1, 0, 1, O_JR,  2'b01);
      addVec(0, 0, 0, 0, 0, 1, O_RUN, 2'b01);
      addVec(0, 1, 0, 0, 1, 1, O_BUB, 2'b01);
      addVec(0, 1, 0, 0, 1, 1, O_BUB, 2'b10);
      addVec(0, 1, 0, 0, 0, 1, O_BUB, 2'b10);
      addVec(0, 0, 0, 0, 0, 1, O_RUN, 2'b01);
      addVec(0, 0, 0, 0, 0, 0, O_WAIT, 2'b01);
      addVec(0, 0, 1, 0, 0, 0, O_J,   2'b01);
      addVec(0, 0, 0, 0, 0, 0, O_WAIT, 2'b01);
      addVec(0, 0, 0, 0, 0, 0, O_WAIT, 2'b01);
      addVec(0, 1, 0, 0, 0, 1, O_BR,  2'b01);
      addVec(0, 1, 1, 0, 0, 1, O_J,   2'b01);
      addVec(0, 0, 0, 0, 1, 1, O_BUB, 2'b01);
      addVec(1, 0, 0, 0, 0, 1, O_RST, 2'b10);
      addVec(0, 0, 0, 0, 0, 1, O_RST, 2'b00);
      addVec(0, 0, 0, 0, 0, 1, O_RST, 2'b00);
      addVec(0, 0, 0, 0, 0, 1, O_RUN, 2'b01);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].br, vecs[i].jmp, vecs[i].jr, vecs[i].lu, vecs[i].rdy,
                       $sformatf("model_vec%0d", i));
         checkOutput($sformatf("table_vec%0d", i), 32'(last_out), 32'(vecs[i].exp));
      end

      // Hold length: first PC advance exactly H cycles after Reset falls.
      applyStimulus(1, 0, 0, 0, 0, 1, "hold_rst");
      found = -1;
      for (int n = 0; n < 20 && found < 0; n++) begin
         applyStimulus(0, 0, 0, 0, 0, 1, "hold_wait");
         if (last_out[5]) found = n;
      end
      checkOutput("hold_len", 32'(found), 32'(H));

`ifdef FETCH_PERF_CNT_EN
      applyStimulus(1, 0, 0, 0, 0, 1, "perf_rst");
      for (int n = 0; n < H; n++) applyStimulus(0, 0, 0, 0, 0, 1, "perf_hold");
      applyStimulus(0, 0, 0, 1, 0, 1, "perf_r0");
      applyStimulus(0, 0, 1, 0, 0, 1, "perf_r1");
      applyStimulus(0, 1, 0, 0, 0, 1, "perf_r2");
      applyStimulus(0, 1, 1, 1, 0, 0, "perf_r3");
      applyStimulus(0, 1, 0, 0, 0, 0, "perf_r4");
      for (int s = 0; s < 2; s++) begin
         applyStimulus(0, 0, 0, 0, 1, 1, "perf_lu");
         for (int k = 1; k < L; k++) applyStimulus(0, 1, 0, 0, 0, 1, "perf_stall");
      end
      for (int w = 0; w < 3; w++) applyStimulus(0, 0, 0, 0, 0, 0, "perf_wait");
      checkOutput("perf_redirect", RedirectCount, 32'd5);
      checkOutput("perf_stall", StallCount, 32'(2 * L));
      checkOutput("perf_wait", IMemWaitCount, 32'd3);
`endif

      // Random traffic against the cycle-count reference model.
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
                       $sformatf("rand%0d", c));
      end

`ifdef FETCH_PERF_CNT_EN
      checkOutput("rand_redirect", RedirectCount, 32'(m_redir));
      checkOutput("rand_stall", StallCount, 32'(m_stall));
      checkOutput("rand_wait", IMemWaitCount, 32'(m_wait));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
